// File: rtl/clock_time_ctrl.sv
// Timekeeping (HH:MM:SS, 24 h), set-time FSM, digit scan and blink mask for the 7-segment driver.
// Optional button debounce filter enabled by defining CLOCK_TIME_CTRL_DEBOUNCE_EN.
module clock_time_ctrl #(
  parameter int TICK_DIV   = 1000,
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_view,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  segment_byte_control,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  if (TICK_DIV < 4 || (TICK_DIV % 2) != 0 || SCAN_DIV < 1 || DEB_CYCLES < 1) begin : g_param_check
    $error("clock_time_ctrl: illegal parameter value");
  end

  logic [2:0]    raw_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    level_s;
  logic [2:0]    prev_r;
  logic [2:0]    ev_r;
  logic          mode_ev_s;
  logic          inc_ev_s;
  logic          view_ev_s;
  logic          exit_s;
  logic          blink_on_s;

  state_t        mode_r;
  state_t        mode_next_s;
  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic [5:0]    hour_r;
  logic          view_r;
  logic [5:0]    sec_next_s;
  logic [5:0]    min_next_s;
  logic [5:0]    hour_next_s;
  logic          view_next_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_next_s;
  logic          sec_tick_r;
  logic [SW-1:0] scan_r;
  logic [2:0]    bs_r;
  logic [3:0]    seg_r;
  logic [3:0]    seg_next_s;

  assign raw_s = {btn_view, btn_inc, btn_mode};

  // Two-flop synchronizer plus registered rising-edge detect on the (filtered) level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      prev_r  <= 3'b000;
      ev_r    <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      prev_r  <= level_s;
      ev_r    <= level_s & ~prev_r;
    end
  end

`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic          filt_r;
    logic [DW-1:0] cnt_r;

    // Filtered level flips only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        filt_r <= 1'b0;
        cnt_r  <= '0;
      end else if (sync2_r[g] != filt_r) begin
        if (cnt_r == DW'(DEB_CYCLES - 1)) begin
          filt_r <= sync2_r[g];
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + DW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end

    assign level_s[g] = filt_r;
  end
`else
  assign level_s = sync2_r;
`endif

  assign mode_ev_s = ev_r[0];
  assign inc_ev_s  = ev_r[1];
  assign view_ev_s = ev_r[2];
  assign exit_s    = mode_ev_s && (mode_r == ST_SET_MIN);

  // Mode FSM next state: each mode event advances one step around the ring
  always_comb begin
    mode_next_s = mode_r;
    if (mode_ev_s) begin
      case (mode_r)
        ST_RUN:      mode_next_s = ST_SET_HOUR;
        ST_SET_HOUR: mode_next_s = ST_SET_MIN;
        ST_SET_MIN:  mode_next_s = ST_RUN;
        default:     mode_next_s = ST_RUN;
      endcase
    end else begin
      mode_next_s = mode_r;
    end
  end

  // Mode state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_r <= ST_RUN;
    end else begin
      mode_r <= mode_next_s;
    end
  end

  // Time fields, view toggle and prescaler next values; mode events mask inc/view
  always_comb begin
    sec_next_s  = sec_r;
    min_next_s  = min_r;
    hour_next_s = hour_r;
    view_next_s = view_r;
    if (mode_r == ST_RUN) begin
      if (sec_tick_r) begin
        if (sec_r == 6'd59) begin
          sec_next_s = 6'd0;
          if (min_r == 6'd59) begin
            min_next_s  = 6'd0;
            hour_next_s = (hour_r == 6'd23) ? 6'd0 : hour_r + 6'd1;
          end else begin
            min_next_s = min_r + 6'd1;
          end
        end else begin
          sec_next_s = sec_r + 6'd1;
        end
      end else begin
        sec_next_s = sec_r;
      end
      if (view_ev_s && !mode_ev_s) begin
        view_next_s = ~view_r;
      end else begin
        view_next_s = view_r;
      end
    end else if (mode_r == ST_SET_HOUR) begin
      if (inc_ev_s && !mode_ev_s) begin
        hour_next_s = (hour_r == 6'd23) ? 6'd0 : hour_r + 6'd1;
      end else begin
        hour_next_s = hour_r;
      end
    end else if (mode_r == ST_SET_MIN) begin
      if (exit_s) begin
        sec_next_s = 6'd0;
      end else if (inc_ev_s) begin
        min_next_s = (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
      end else begin
        min_next_s = min_r;
      end
    end else begin
      sec_next_s = sec_r;
    end

    if (exit_s || pre_r == PRE_MAX) begin
      pre_next_s = '0;
    end else begin
      pre_next_s = pre_r + PW'(1);
    end
  end

  // Time, view and prescaler registers; tick is suppressed in set modes and on the exit cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hour_r     <= 6'd0;
      view_r     <= 1'b0;
      pre_r      <= '0;
      sec_tick_r <= 1'b0;
    end else begin
      sec_r      <= sec_next_s;
      min_r      <= min_next_s;
      hour_r     <= hour_next_s;
      view_r     <= view_next_s;
      pre_r      <= pre_next_s;
      sec_tick_r <= (pre_r == PRE_MAX) && (mode_r == ST_RUN) && (mode_next_s == ST_RUN);
    end
  end

  assign blink_on_s = (pre_r < PRE_HALF);

  // Digit-enable mask: the field being set blinks with the prescaler half-period
  always_comb begin
    seg_next_s = 4'b1111;
    case (mode_r)
      ST_RUN:      seg_next_s = 4'b1111;
      ST_SET_HOUR: seg_next_s = {blink_on_s, blink_on_s, 1'b1, 1'b1};
      ST_SET_MIN:  seg_next_s = {1'b1, 1'b1, blink_on_s, blink_on_s};
      default:     seg_next_s = 4'b1111;
    endcase
  end

  // Scan divider and digit index, plus registered blink mask
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_r <= '0;
      bs_r   <= 3'd0;
      seg_r  <= 4'b1111;
    end else begin
      seg_r <= seg_next_s;
      if (scan_r == SCAN_MAX) begin
        scan_r <= '0;
        bs_r   <= bs_r + 3'd1;
      end else begin
        scan_r <= scan_r + SW'(1);
      end
    end
  end

  assign data_show            = (!view_r || mode_r != ST_RUN) ? {hour_r, min_r} : {min_r, sec_r};
  assign byte_status          = bs_r;
  assign segment_byte_control = seg_r;
  assign mode                 = mode_r;
  assign sec_tick             = sec_tick_r;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed, table-driven bench for clock_time_ctrl (TICK_DIV=10, SCAN_DIV=2, DEB_CYCLES=8).
module tb_clock_time_ctrl;

  localparam int TD = 10;
  localparam int SD = 2;
  localparam int DB = 8;
`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
  localparam int HOLD = DB + 2;
  localparam int GAP  = DB + 6;
`else
  localparam int HOLD = 1;
  localparam int GAP  = 4;
`endif
  localparam int PLEN = HOLD + GAP;

  logic        clock;
  logic        reset;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_view;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [3:0]  segment_byte_control;
  logic [1:0]  mode;
  logic        sec_tick;

  clock_time_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
    .clock                (clock),
    .reset                (reset),
    .btn_mode             (btn_mode),
    .btn_inc              (btn_inc),
    .btn_view             (btn_view),
    .data_show            (data_show),
    .byte_status          (byte_status),
    .segment_byte_control (segment_byte_control),
    .mode                 (mode),
    .sec_tick             (sec_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising edges since reset release: the scan index is a pure function of this
  int cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          btn;   // 0 mode, 1 inc, 2 view, 3 mode+inc together
    int          reps;
    logic [1:0]  emode;
    logic [11:0] edata;
  } vec_t;

  vec_t vecs [14];

  task automatic press(input int btn);
    btn_mode = (btn == 0 || btn == 3);
    btn_inc  = (btn == 1 || btn == 3);
    btn_view = (btn == 2);
    repeat (HOLD) @(negedge clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_view = 1'b0;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic run_vec(input int k);
    for (int r = 0; r < vecs[k].reps; r++) press(vecs[k].btn);
    check($sformatf("vec%0d_mode", k), mode, vecs[k].emode);
    check($sformatf("vec%0d_data", k), data_show, vecs[k].edata);
  endtask

  task automatic scan_check();
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      check("scan_index", byte_status, (cyc / 2) % 8);
    end
  endtask

  task automatic blink_check(input logic [3:0] off);
    logic [3:0] s [20];
    int ticks_seen = 0;
    int idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      s[i] = segment_byte_control;
      if (sec_tick) ticks_seen++;
    end
    check("set_tick_forced_zero", ticks_seen, 0);
    for (int i = 1; i <= 10; i++) begin
      if (idx < 0 && s[i-1] == 4'b1111 && s[i] == off) idx = i;
    end
    check("blink_phase_found", (idx >= 0), 1);
    if (idx >= 0) begin
      for (int j = 0; j < 10; j++) begin
        check("blink_pattern", s[idx+j], (j < 5) ? off : 4'b1111);
      end
    end
  endtask

  task automatic exit_and_time(input logic [11:0] exp_data);
    int found = 0;
    int n = 0;
    btn_mode = 1'b1;
    repeat (HOLD) @(negedge clock);
    btn_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mode == 2'd0) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    check("exit_to_run", found, 1);
    check("exit_data", data_show, exp_data);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n++;
      if (sec_tick) break;
    end
    check("first_tick_latency", n, TD);
  endtask

  initial begin
    int ticks;
    int since;
    int found;
    int bad;

    vecs[0]  = '{0, 1,  2'd1, {6'd0,  6'd0}};
    vecs[1]  = '{1, 25, 2'd1, {6'd1,  6'd0}};
    vecs[2]  = '{0, 1,  2'd2, {6'd1,  6'd0}};
    vecs[3]  = '{1, 61, 2'd2, {6'd1,  6'd1}};
    vecs[4]  = '{0, 1,  2'd1, {6'd1,  6'd2}};
    vecs[5]  = '{1, 22, 2'd1, {6'd23, 6'd2}};
    vecs[6]  = '{3, 1,  2'd2, {6'd23, 6'd2}};
    vecs[7]  = '{1, 57, 2'd2, {6'd23, 6'd59}};
    vecs[8]  = '{2, 1,  2'd0, {6'd0,  6'd0}};
    vecs[9]  = '{0, 1,  2'd1, {6'd0,  6'd0}};
    vecs[10] = '{1, 5,  2'd1, {6'd5,  6'd0}};
    vecs[11] = '{0, 1,  2'd2, {6'd5,  6'd0}};
    vecs[12] = '{1, 7,  2'd2, {6'd5,  6'd7}};
    vecs[13] = '{0, 1,  2'd0, {6'd5,  6'd7}};

    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_view = 1'b0;
    @(negedge clock);
    check("rst_data", data_show, 12'd0);
    check("rst_seg", segment_byte_control, 4'b1111);
    check("rst_mode", mode, 2'd0);
    check("rst_tick", sec_tick, 1'b0);
    check("rst_scan", byte_status, 3'd0);
    @(negedge clock);
    reset = 1'b1;

    scan_check();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (segment_byte_control != 4'b1111) bad++;
    end
    check("run_seg_all_on", bad, 0);

    for (int k = 0; k < 4; k++) run_vec(k);
    blink_check(4'b1100);
    scan_check();

    btn_inc = 1'b1;
    repeat (100) @(negedge clock);
    btn_inc = 1'b0;
    repeat (PLEN) @(negedge clock);
    check("held_inc_once", data_show, {6'd1, 6'd2});
`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
    btn_inc = 1'b1;
    repeat (5) @(negedge clock);
    btn_inc = 1'b0;
    repeat (PLEN) @(negedge clock);
    check("glitch_filtered", data_show, {6'd1, 6'd2});
`endif

    exit_and_time({6'd1, 6'd2});
    press(2);
    check("view_mmss_after_exit", data_show, {6'd2, 6'(1 + (PLEN - 1) / 10)});
    press(2);
    check("view_back_hhmm", data_show, {6'd1, 6'd2});

    for (int k = 4; k < 6; k++) run_vec(k);
    blink_check(4'b0011);
    scan_check();
    for (int k = 6; k < 8; k++) run_vec(k);

    exit_and_time({6'd23, 6'd59});
    ticks = 1;
    since = 0;
    for (int i = 0; i < 700 && ticks < 60; i++) begin
      @(negedge clock);
      since++;
      if (sec_tick) begin
        ticks++;
        check("tick_period", since, TD);
        since = 0;
        if (ticks == 59) check("pre_rollover", data_show, {6'd23, 6'd59});
      end
    end
    check("rollover_tick_count", ticks, 60);
    @(negedge clock);
    check("rollover_hhmm", data_show, 12'd0);
    press(2);
    check("rollover_mmss", data_show, {6'd0, 6'(PLEN / 10)});

    for (int k = 8; k < 14; k++) run_vec(k);

    press(2);
    found = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (data_show == {6'd7, 6'd33}) begin
        found = 1;
        break;
      end
    end
    check("reach_05_07_33", found, 1);

    #2 reset = 1'b0;
    #1;
    check("async_rst_data", data_show, 12'd0);
    check("async_rst_seg", segment_byte_control, 4'b1111);
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_tick", sec_tick, 1'b0);
    check("async_rst_scan", byte_status, 3'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    scan_check();
    check("post_rst_data", data_show, 12'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and display-control stage directly upstream of the 7-segment digit driver.
- Counts seconds, minutes and hours (24 h), and runs a set-time state machine driven by three buttons.
- Generates the digit-scan index, the 12-bit display value and the per-digit enable mask (blink) that the driver consumes.

Parameters:
- TICK_DIV, 1000, clock cycles per second; must be ≥4 and even.
- SCAN_DIV, 16, clock cycles per byte_status step; must be ≥1.
- DEB_CYCLES, 8, consecutive stable samples required by the optional debounce filter.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button: cycle RUN→SET_HOUR→SET_MIN→RUN.
- btn_inc  in  1  raw button: increment the field being set.
- btn_view  in  1  raw button: toggle HH:MM / MM:SS view in RUN.
- data_show  out  12  {high field[11:6], low field[5:0]}, each field binary 0..59.
- byte_status  out  3  scan index 0..7; the driver lights a digit on even values only.
- segment_byte_control  out  4  digit enable, active-high. bit0=low-field ones, bit1=low-field tens, bit2=high-field ones, bit3=high-field tens.
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN.
- sec_tick  out  1  one-cycle pulse at each counted second.

Behaviour:
- Reset (async assert, sync-style release):
  - sec=min=hour=0, prescaler=0, scan counter=0, byte_status=0, mode=RUN, view=0.
  - data_show=0, segment_byte_control=4'b1111, sec_tick=0, button sync/edge state=0.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then rising-edge detection.
  - A press is a 1-cycle event, registered 3 cycles after the raw edge.
  - A held button yields one event only.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN. sec_tick=1 in the cycle the prescaler equals TICK_DIV-1 (registered), then the prescaler wraps to 0.
  - In SET_HOUR/SET_MIN the prescaler keeps running for blink; sec_tick is forced 0 and seconds are frozen.
- Time update on sec_tick (RUN only):
  - sec++. At sec=59: sec→0, min++. At min=59: min→0, hour++. At hour=23: hour→0.
  - 23:59:59 → 00:00:00 in one tick.
- FSM:
  - RUN --mode--> SET_HOUR --mode--> SET_MIN --mode--> RUN.
  - On SET_MIN→RUN: sec←0 and prescaler←0 in the same cycle, so the first sec_tick follows exactly TICK_DIV cycles later.
- Increment events:
  - SET_HOUR: hour = (hour==23)?0:hour+1.
  - SET_MIN: min = (min==59)?0:min+1. No carry into hour.
  - RUN: ignored.
- Simultaneous events: a mode event takes priority and an inc event in the same cycle is dropped. A view event in the same cycle as a mode event is dropped.
- View:
  - A view event toggles view in RUN only.
  - data_show = (view==0 or mode!=RUN) ? {hour,min} : {min,sec}.
  - data_show is a combinational mux of registered fields.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1; on wrap, byte_status increments mod 8 (7→0).
  - Scan runs in all modes.
- Blink:
  - blink_on = (prescaler < TICK_DIV/2).
  - segment_byte_control is registered, 1-cycle latency from mode/prescaler:
    - RUN: 1111.
    - SET_HOUR: {blink_on,blink_on,1,1}.
    - SET_MIN: {1,1,blink_on,blink_on}.
- Width rules: all fields are 6-bit unsigned; upper bits of hour are always 0; no value outside its range is ever reachable.

Optional Feature:
- Macro: CLOCK_TIME_CTRL_DEBOUNCE_EN.
- Defined: each synchronized button feeds a counter. The filtered level changes only after DEB_CYCLES consecutive samples differ from the current filtered level, and edge detection runs on the filtered level. Press-event latency = 2 sync cycles + DEB_CYCLES + 1.
- Undefined: no filter; press latency is 3 cycles as above. Ports and all other behaviour are identical.

Test Plan:
- Reset: TICK_DIV=10, SCAN_DIV=2, drop reset mid-count at time 05:07:33. Expect all outputs at reset values immediately (async), data_show=0, control=1111.
- Rollover: preload via SET to 23:59, exit to RUN, run 60 ticks, then view MM:SS. Expect data_show={0,0}, then 00:00:00 with hour=0; sec_tick period is exactly 10 cycles.
- Set FSM:
  - mode, inc×25 → hour=1 (23→0 wrap).
  - mode, inc×61 → min=1.
  - mode → RUN with sec=0; the first sec_tick arrives 10 cycles later.
  - mode=1 then 2 then 0 throughout.
- Blink: in SET_HOUR with TICK_DIV=10, control = 1111 for prescaler 0..4 and 0011 for 5..9 (one cycle late). SET_MIN gives 1100 in the off phase.
- Scan: SCAN_DIV=2, byte_status sequence 0,0,1,1,...,7,7,0 in every mode.
- Simultaneous and held buttons: mode and inc pulsed in the same cycle in SET_HOUR → mode advances to SET_MIN, hour unchanged. btn_inc held 100 cycles → exactly one increment. With the macro defined and DEB_CYCLES=8, a 5-cycle glitch produces no event.
